// File: rtl/ahb_sram_arb_pkg.sv
// rtl/ahb_sram_arb_pkg.sv - shared encodings for the two-master AHB-lite SRAM arbiter
//
// Purpose: AHB transfer/burst codes, per-master request state and master ids
// used by ahb_sram_arb and ahb_sram_req_buf.
package ahb_sram_arb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    typedef enum logic [1:0] {
        MST_IDLE = 2'd0,
        MST_PEND = 2'd1,
        MST_DATA = 2'd2
    } mst_state_t;

endpackage

// File: rtl/ahb_sram_req_buf.sv
// rtl/ahb_sram_req_buf.sv - per-master request tracker with one-entry address-phase buffer
//
// Purpose: tracks one master's IDLE/PEND/DATA state, captures a losing
// address phase for replay and generates that master's hready.
// Ports:
//   hclk, hresetn          clock, asynchronous active-low reset
//   i_hsel, i_htrans_act   live select and htrans[1] from the master
//   i_hwrite/hsize/hburst/haddr  live address-phase fields
//   i_s_hreadyout          slave ready
//   i_grant                this master wins the slave this cycle
//   o_req                  live request (masked while stalled)
//   o_pend                 buffered request waiting for a grant
//   o_hwrite/hsize/hburst/haddr  buffered address-phase fields
//   o_hready               hready returned to the master
module ahb_sram_req_buf
    import ahb_sram_arb_pkg::*;
#(
    parameter int AWIDTH = 32
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic              i_hsel,
    input  logic              i_htrans_act,
    input  logic              i_hwrite,
    input  logic [2:0]        i_hsize,
    input  logic [2:0]        i_hburst,
    input  logic [AWIDTH-1:0] i_haddr,
    input  logic              i_s_hreadyout,
    input  logic              i_grant,
    output logic              o_req,
    output logic              o_pend,
    output logic              o_hwrite,
    output logic [2:0]        o_hsize,
    output logic [2:0]        o_hburst,
    output logic [AWIDTH-1:0] o_haddr,
    output logic              o_hready
);

    mst_state_t        r_state;
    mst_state_t        w_next;
    logic              w_capture;
    logic              r_hwrite;
    logic [2:0]        r_hsize;
    logic [2:0]        r_hburst;
    logic [AWIDTH-1:0] r_haddr;

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_state  <= MST_IDLE;
            r_hwrite <= 1'b0;
            r_hsize  <= 3'd0;
            r_hburst <= 3'd0;
            r_haddr  <= '0;
        end else begin
            r_state <= w_next;
            if (w_capture) begin
                r_hwrite <= i_hwrite;
                r_hsize  <= i_hsize;
                r_hburst <= i_hburst;
                r_haddr  <= i_haddr;
            end
        end
    end

    // State only moves on slave-ready cycles; a wait state freezes everything.
    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        if (i_s_hreadyout) begin
            if (i_grant) begin
                w_next = MST_DATA;
            end else if (o_req) begin
                w_next    = MST_PEND;
                w_capture = 1'b1;
            end else if (r_state == MST_DATA) begin
                w_next = MST_IDLE;
            end
        end
    end

    assign o_hready = (r_state == MST_PEND) ? 1'b0 :
                      (r_state == MST_DATA) ? i_s_hreadyout : 1'b1;
    assign o_req    = i_hsel & i_htrans_act & o_hready;
    assign o_pend   = (r_state == MST_PEND);
    assign o_hwrite = r_hwrite;
    assign o_hsize  = r_hsize;
    assign o_hburst = r_hburst;
    assign o_haddr  = r_haddr;

endmodule

// File: rtl/ahb_sram_arb.sv
// rtl/ahb_sram_arb.sv - two-master AHB-lite arbiter in front of the on-chip SRAM slave
//
// Purpose: shares one SRAM slave between instruction fetch (m0) and
// load/store (m1); a losing address phase is buffered and replayed.
// Build option: define AHB_SRAM_ARB_RR_EN for round-robin arbitration,
// otherwise m1 has fixed priority over m0.
// Ports:
//   hclk, hresetn                      clock, asynchronous active-low reset
//   m0_*_i / m1_*_i                    AHB-lite slave-side inputs per master
//   m0_hready_o/hresp_o/hrdata_o (m1)  responses per master
//   s_hsel_o..s_hwdata_o               address/data phase to the SRAM slave
//   s_hready_o                         hready fed back into the slave
//   s_hreadyout_i, s_hresp_i, s_hrdata_i  slave response
module ahb_sram_arb
    import ahb_sram_arb_pkg::*;
#(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic              m0_hsel_i,
    input  logic [1:0]        m0_htrans_i,
    input  logic              m0_hwrite_i,
    input  logic [2:0]        m0_hsize_i,
    input  logic [2:0]        m0_hburst_i,
    input  logic [AWIDTH-1:0] m0_haddr_i,
    input  logic [DWIDTH-1:0] m0_hwdata_i,
    output logic              m0_hready_o,
    output logic              m0_hresp_o,
    output logic [DWIDTH-1:0] m0_hrdata_o,
    input  logic              m1_hsel_i,
    input  logic [1:0]        m1_htrans_i,
    input  logic              m1_hwrite_i,
    input  logic [2:0]        m1_hsize_i,
    input  logic [2:0]        m1_hburst_i,
    input  logic [AWIDTH-1:0] m1_haddr_i,
    input  logic [DWIDTH-1:0] m1_hwdata_i,
    output logic              m1_hready_o,
    output logic              m1_hresp_o,
    output logic [DWIDTH-1:0] m1_hrdata_o,
    output logic              s_hsel_o,
    output logic [1:0]        s_htrans_o,
    output logic              s_hwrite_o,
    output logic [2:0]        s_hsize_o,
    output logic [2:0]        s_hburst_o,
    output logic [AWIDTH-1:0] s_haddr_o,
    output logic [DWIDTH-1:0] s_hwdata_o,
    output logic              s_hready_o,
    input  logic              s_hreadyout_i,
    input  logic              s_hresp_i,
    input  logic [DWIDTH-1:0] s_hrdata_i
);

    logic              w_req0, w_req1, w_pend0, w_pend1;
    logic              w_grant0, w_grant1;
    logic              w_b0_hwrite, w_b1_hwrite;
    logic [2:0]        w_b0_hsize, w_b1_hsize, w_b0_hburst, w_b1_hburst;
    logic [AWIDTH-1:0] w_b0_haddr, w_b1_haddr;
    logic              w_cand0, w_cand1;
    logic              w_win_vld, w_win_id;
    logic              r_dp_vld, r_dp_own;
    logic              r_lock_vld, r_lock_id;
`ifdef AHB_SRAM_ARB_RR_EN
    logic              r_rr_ptr;
`endif

    ahb_sram_req_buf #(.AWIDTH(AWIDTH)) u_buf0 (
        .hclk(hclk), .hresetn(hresetn),
        .i_hsel(m0_hsel_i), .i_htrans_act(m0_htrans_i[1]), .i_hwrite(m0_hwrite_i),
        .i_hsize(m0_hsize_i), .i_hburst(m0_hburst_i), .i_haddr(m0_haddr_i),
        .i_s_hreadyout(s_hreadyout_i), .i_grant(w_grant0),
        .o_req(w_req0), .o_pend(w_pend0), .o_hwrite(w_b0_hwrite), .o_hsize(w_b0_hsize),
        .o_hburst(w_b0_hburst), .o_haddr(w_b0_haddr), .o_hready(m0_hready_o)
    );

    ahb_sram_req_buf #(.AWIDTH(AWIDTH)) u_buf1 (
        .hclk(hclk), .hresetn(hresetn),
        .i_hsel(m1_hsel_i), .i_htrans_act(m1_htrans_i[1]), .i_hwrite(m1_hwrite_i),
        .i_hsize(m1_hsize_i), .i_hburst(m1_hburst_i), .i_haddr(m1_haddr_i),
        .i_s_hreadyout(s_hreadyout_i), .i_grant(w_grant1),
        .o_req(w_req1), .o_pend(w_pend1), .o_hwrite(w_b1_hwrite), .o_hsize(w_b1_hsize),
        .o_hburst(w_b1_hburst), .o_haddr(w_b1_haddr), .o_hready(m1_hready_o)
    );

    // A stalled master cannot raise a live request, so pend and req never
    // coexist for the same master and at most one buffer is ever occupied.
    assign w_cand0 = w_pend0 | w_req0;
    assign w_cand1 = w_pend1 | w_req1;

    // During wait states the occupied buffer is presented (stable) but not
    // granted. The locked buffer then wins when the slave becomes ready, so
    // an address phase shown through the wait is the one actually taken.
    always_comb begin
        w_win_vld = 1'b0;
        w_win_id  = M0;
        if (s_hreadyout_i) begin
            if (r_lock_vld) begin
                w_win_vld = 1'b1;
                w_win_id  = r_lock_id;
            end else if (w_cand0 && w_cand1) begin
                w_win_vld = 1'b1;
`ifdef AHB_SRAM_ARB_RR_EN
                w_win_id  = r_rr_ptr;
`else
                w_win_id  = M1;
`endif
            end else if (w_cand0 || w_cand1) begin
                w_win_vld = 1'b1;
                w_win_id  = w_cand1 ? M1 : M0;
            end
        end else if (w_pend0 || w_pend1) begin
            w_win_vld = 1'b1;
            w_win_id  = w_pend1 ? M1 : M0;
        end
    end

    assign w_grant0 = s_hreadyout_i & w_win_vld & (w_win_id == M0);
    assign w_grant1 = s_hreadyout_i & w_win_vld & (w_win_id == M1);

    always_comb begin
        s_hsel_o   = 1'b0;
        s_htrans_o = HTRANS_IDLE;
        s_hwrite_o = 1'b0;
        s_hsize_o  = 3'd0;
        s_hburst_o = HBURST_SINGLE;
        s_haddr_o  = '0;
        if (w_win_vld) begin
            s_hsel_o = 1'b1;
            if (w_win_id == M1) begin
                if (w_pend1) begin
                    s_htrans_o = HTRANS_NONSEQ;
                    s_hwrite_o = w_b1_hwrite;
                    s_hsize_o  = w_b1_hsize;
                    s_hburst_o = w_b1_hburst;
                    s_haddr_o  = w_b1_haddr;
                end else begin
                    s_htrans_o = m1_htrans_i;
                    s_hwrite_o = m1_hwrite_i;
                    s_hsize_o  = m1_hsize_i;
                    s_hburst_o = m1_hburst_i;
                    s_haddr_o  = m1_haddr_i;
                end
            end else begin
                if (w_pend0) begin
                    s_htrans_o = HTRANS_NONSEQ;
                    s_hwrite_o = w_b0_hwrite;
                    s_hsize_o  = w_b0_hsize;
                    s_hburst_o = w_b0_hburst;
                    s_haddr_o  = w_b0_haddr;
                end else begin
                    s_htrans_o = m0_htrans_i;
                    s_hwrite_o = m0_hwrite_i;
                    s_hsize_o  = m0_hsize_i;
                    s_hburst_o = m0_hburst_i;
                    s_haddr_o  = m0_haddr_i;
                end
            end
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_dp_vld   <= 1'b0;
            r_dp_own   <= M0;
            r_lock_vld <= 1'b0;
            r_lock_id  <= M0;
        end else if (s_hreadyout_i) begin
            r_dp_vld   <= w_win_vld;
            r_dp_own   <= w_win_id;
            r_lock_vld <= 1'b0;
        end else begin
            r_lock_vld <= w_win_vld;
            r_lock_id  <= w_win_id;
        end
    end

`ifdef AHB_SRAM_ARB_RR_EN
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_rr_ptr <= M0;
        end else if (s_hreadyout_i && w_win_vld) begin
            r_rr_ptr <= ~w_win_id;
        end
    end
`endif

    assign s_hwdata_o  = !r_dp_vld ? '0 : (r_dp_own == M1) ? m1_hwdata_i : m0_hwdata_i;
    assign m0_hrdata_o = (r_dp_vld && r_dp_own == M0) ? s_hrdata_i : '0;
    assign m1_hrdata_o = (r_dp_vld && r_dp_own == M1) ? s_hrdata_i : '0;
    assign m0_hresp_o  = r_dp_vld & (r_dp_own == M0) & s_hresp_i;
    assign m1_hresp_o  = r_dp_vld & (r_dp_own == M1) & s_hresp_i;
    assign s_hready_o  = s_hreadyout_i;

endmodule

// File: tb/tb_ahb_sram_arb.sv
// tb/tb_ahb_sram_arb.sv - directed vector bench for ahb_sram_arb
module tb_ahb_sram_arb;
    import ahb_sram_arb_pkg::*;

    logic        hclk = 1'b0;
    logic        hresetn = 1'b0;
    logic        m0_hsel_i, m0_hwrite_i, m1_hsel_i, m1_hwrite_i;
    logic [1:0]  m0_htrans_i, m1_htrans_i;
    logic [2:0]  m0_hsize_i, m0_hburst_i, m1_hsize_i, m1_hburst_i;
    logic [31:0] m0_haddr_i, m0_hwdata_i, m1_haddr_i, m1_hwdata_i;
    logic        m0_hready_o, m0_hresp_o, m1_hready_o, m1_hresp_o;
    logic [31:0] m0_hrdata_o, m1_hrdata_o;
    logic        s_hsel_o, s_hwrite_o, s_hready_o;
    logic [1:0]  s_htrans_o;
    logic [2:0]  s_hsize_o, s_hburst_o;
    logic [31:0] s_haddr_o, s_hwdata_o;
    logic        s_hreadyout_i, s_hresp_i;
    logic [31:0] s_hrdata_i;

    always #5 hclk = ~hclk;

    ahb_sram_arb #(.AWIDTH(32), .DWIDTH(32)) dut (
        .hclk(hclk), .hresetn(hresetn),
        .m0_hsel_i(m0_hsel_i), .m0_htrans_i(m0_htrans_i), .m0_hwrite_i(m0_hwrite_i),
        .m0_hsize_i(m0_hsize_i), .m0_hburst_i(m0_hburst_i), .m0_haddr_i(m0_haddr_i),
        .m0_hwdata_i(m0_hwdata_i), .m0_hready_o(m0_hready_o), .m0_hresp_o(m0_hresp_o),
        .m0_hrdata_o(m0_hrdata_o),
        .m1_hsel_i(m1_hsel_i), .m1_htrans_i(m1_htrans_i), .m1_hwrite_i(m1_hwrite_i),
        .m1_hsize_i(m1_hsize_i), .m1_hburst_i(m1_hburst_i), .m1_haddr_i(m1_haddr_i),
        .m1_hwdata_i(m1_hwdata_i), .m1_hready_o(m1_hready_o), .m1_hresp_o(m1_hresp_o),
        .m1_hrdata_o(m1_hrdata_o),
        .s_hsel_o(s_hsel_o), .s_htrans_o(s_htrans_o), .s_hwrite_o(s_hwrite_o),
        .s_hsize_o(s_hsize_o), .s_hburst_o(s_hburst_o), .s_haddr_o(s_haddr_o),
        .s_hwdata_o(s_hwdata_o), .s_hready_o(s_hready_o),
        .s_hreadyout_i(s_hreadyout_i), .s_hresp_i(s_hresp_i), .s_hrdata_i(s_hrdata_i)
    );

    typedef struct {
        bit          m0r, m0w;
        logic [31:0] m0a, m0d;
        bit          m1r, m1w;
        logic [31:0] m1a, m1d;
        bit          rdy, resp;
        logic [31:0] rd;
        bit          e0r, e1r, e0p, e1p;
        logic [31:0] e0d, e1d;
        bit          esel, ewr;
        logic [31:0] ea, ewd;
    } vec_t;

    vec_t vecs[16];
    int   total = 0;
    int   bad = 0;

    function automatic vec_t mk(
        bit m0r, bit m0w, logic [31:0] m0a, logic [31:0] m0d,
        bit m1r, bit m1w, logic [31:0] m1a, logic [31:0] m1d,
        bit rdy, bit resp, logic [31:0] rd,
        bit e0r, bit e1r, bit e0p, bit e1p, logic [31:0] e0d, logic [31:0] e1d,
        bit esel, bit ewr, logic [31:0] ea, logic [31:0] ewd);
        vec_t v;
        v.m0r = m0r; v.m0w = m0w; v.m0a = m0a; v.m0d = m0d;
        v.m1r = m1r; v.m1w = m1w; v.m1a = m1a; v.m1d = m1d;
        v.rdy = rdy; v.resp = resp; v.rd = rd;
        v.e0r = e0r; v.e1r = e1r; v.e0p = e0p; v.e1p = e1p; v.e0d = e0d; v.e1d = e1d;
        v.esel = esel; v.ewr = ewr; v.ea = ea; v.ewd = ewd;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        m0_hsel_i   = v.m0r;
        m0_htrans_i = v.m0r ? HTRANS_NONSEQ : HTRANS_IDLE;
        m0_hwrite_i = v.m0w;
        m0_haddr_i  = v.m0a;
        m0_hwdata_i = v.m0d;
        m1_hsel_i   = v.m1r;
        m1_htrans_i = v.m1r ? HTRANS_NONSEQ : HTRANS_IDLE;
        m1_hwrite_i = v.m1w;
        m1_haddr_i  = v.m1a;
        m1_hwdata_i = v.m1d;
        s_hreadyout_i = v.rdy;
        s_hresp_i     = v.resp;
        s_hrdata_i    = v.rd;
    endtask

    function automatic logic [136:0] pack_exp(input vec_t v);
        logic [1:0] tr;
        tr = v.esel ? HTRANS_NONSEQ : HTRANS_IDLE;
        return {v.e0r, v.e1r, v.e0p, v.e1p, v.e0d, v.e1d, v.esel, tr, v.ewr, v.ea, v.ewd, v.rdy};
    endfunction

    function automatic logic [136:0] pack_act();
        return {m0_hready_o, m1_hready_o, m0_hresp_o, m1_hresp_o, m0_hrdata_o, m1_hrdata_o,
                s_hsel_o, s_htrans_o, s_hwrite_o, s_haddr_o, s_hwdata_o, s_hready_o};
    endfunction

    task automatic check(input string name, input logic [136:0] act, input logic [136:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    vec_t idle_v;
    vec_t v_tmp;
    logic [1:0] exp_rdy_pend;

    initial begin
        idle_v = mk(0,0,0,0, 0,0,0,0, 1,0,0, 1,1,0,0,0,0, 0,0,0,0);
        drive(idle_v);
        m0_hsize_i = 3'd2; m0_hburst_i = HBURST_SINGLE;
        m1_hsize_i = 3'd2; m1_hburst_i = HBURST_SINGLE;
        repeat (2) @(negedge hclk);
        #2 check("reset_state", pack_act(), pack_exp(idle_v));
        @(negedge hclk);
        hresetn = 1'b1;

`ifndef AHB_SRAM_ARB_RR_EN
        // m0 alone: read 0x10
        vecs[0]  = idle_v;
        vecs[1]  = mk(1,0,32'h10,0, 0,0,0,0, 1,0,0, 1,1,0,0,0,0, 1,0,32'h10,0);
        vecs[2]  = mk(0,0,0,0, 0,0,0,0, 1,0,32'hCAFE_F00D, 1,1,0,0,32'hCAFE_F00D,0, 0,0,0,0);
        // collision, m1 (fixed priority) first, m0 replayed
        vecs[3]  = mk(1,0,32'h20,0, 1,1,32'h8000_0004,0, 1,0,0, 1,1,0,0,0,0, 1,1,32'h8000_0004,0);
        vecs[4]  = mk(0,0,0,0, 0,0,0,32'h1234_5678, 1,0,32'hDEAD_0001, 0,1,0,0,0,32'hDEAD_0001, 1,0,32'h20,32'h1234_5678);
        vecs[5]  = mk(0,0,0,0, 0,0,0,0, 1,0,32'hA5A5_0020, 1,1,0,0,32'hA5A5_0020,0, 0,0,0,0);
        // collision then two slave wait states on m1; buffered m0 held on the bus
        vecs[6]  = mk(1,0,32'h30,0, 1,0,32'h40,0, 1,0,0, 1,1,0,0,0,0, 1,0,32'h40,0);
        vecs[7]  = mk(0,0,0,0, 0,0,0,0, 0,0,32'h1111_1111, 0,0,0,0,0,32'h1111_1111, 1,0,32'h30,0);
        vecs[8]  = mk(0,0,0,0, 0,0,0,0, 0,0,32'h1111_1111, 0,0,0,0,0,32'h1111_1111, 1,0,32'h30,0);
        vecs[9]  = mk(0,0,0,0, 1,0,32'h44,0, 1,0,32'hBEEF_0040, 0,1,0,0,0,32'hBEEF_0040, 1,0,32'h30,0);
        vecs[10] = mk(0,0,0,0, 0,0,0,0, 1,0,32'h30, 1,0,0,0,32'h30,0, 1,0,32'h44,0);
        vecs[11] = mk(0,0,0,0, 0,0,0,0, 1,0,32'h44, 1,1,0,0,0,32'h44, 0,0,0,0);
        // collision, then two-cycle ERROR response to m1
        vecs[12] = mk(1,0,32'h60,0, 1,1,32'h50,0, 1,0,0, 1,1,0,0,0,0, 1,1,32'h50,0);
        vecs[13] = mk(0,0,0,0, 0,0,0,32'h0BAD_0050, 0,1,0, 0,0,0,1,0,0, 1,0,32'h60,32'h0BAD_0050);
        vecs[14] = mk(0,0,0,0, 0,0,0,32'h0BAD_0050, 1,1,0, 0,1,0,1,0,0, 1,0,32'h60,32'h0BAD_0050);
        vecs[15] = mk(0,0,0,0, 0,0,0,0, 1,0,32'h66, 1,1,0,0,32'h66,0, 0,0,0,0);
        for (int i = 0; i < 16; i++) begin
            @(negedge hclk);
            drive(vecs[i]);
            #2 check($sformatf("vec%0d", i), pack_act(), pack_exp(vecs[i]));
        end
        exp_rdy_pend = 2'b01;
`else
        // round-robin from reset: m0 first, m1 write replayed one cycle later
        @(negedge hclk);
        drive(mk(1,0,32'h20,0, 1,1,32'h8000_0004,0, 1,0,0, 1,1,0,0,0,0, 0,0,0,0));
        #2 check("rr_first", {104'd0, m1_hready_o, s_haddr_o}, {104'd0, 1'b1, 32'h20});
        @(negedge hclk);
        v_tmp = idle_v; v_tmp.m1d = 32'h1234_5678;
        drive(v_tmp);
        #2 check("rr_replay", {104'd0, m1_hready_o, s_haddr_o, s_hwrite_o},
                 {104'd0, 1'b0, 32'h8000_0004, 1'b1});
        @(negedge hclk);
        drive(v_tmp);
        #2 check("rr_wdata", {104'd0, m1_hready_o, s_hwdata_o}, {104'd0, 1'b1, 32'h1234_5678});
        exp_rdy_pend = 2'b10;
`endif

        // reset while one master is buffered
        @(negedge hclk);
        drive(mk(1,0,32'h70,0, 1,0,32'h74,0, 1,0,0, 1,1,0,0,0,0, 0,0,0,0));
        @(negedge hclk);
        drive(idle_v);
        #2 check("pend_before_rst", {135'd0, m0_hready_o, m1_hready_o}, {135'd0, exp_rdy_pend});
        #1 hresetn = 1'b0;
        #1 check("async_rst", {132'd0, m0_hready_o, m1_hready_o, s_hsel_o, s_htrans_o},
                 {132'd0, 1'b1, 1'b1, 1'b0, HTRANS_IDLE});
        @(negedge hclk);
        hresetn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge hclk);
            #2 check($sformatf("post_rst%0d", c),
                     {100'd0, m0_hready_o, m1_hready_o, s_hsel_o, s_htrans_o, s_haddr_o},
                     {100'd0, 1'b1, 1'b1, 1'b0, HTRANS_IDLE, 32'd0});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
